// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory-wait timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_rw,
    output logic        mem_to_reg,
    output logic        pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] retired,
    output logic        illegal,
    output logic        timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        retired_q;
    logic               illegal_q;
    logic               timeout_q;
    logic               waiting;
    logic               wait_expired;
    logic               set_illegal;
    logic               set_timeout;

    assign state        = state_q;
    assign retired      = retired_q;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;

    // A stalled access is abandoned when this cycle would be the MEM_TIMEOUT-th wait
    assign wait_expired = (32'(wait_cnt) + 32'd1) >= 32'(MEM_TIMEOUT);

    // Next-state and control decode from current state and live inputs
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_rw      = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 2'd0;
        instr_done  = 1'b0;
        waiting     = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_expired) begin
                        set_timeout = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 2'd1;
                case (opcode)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src_b = 2'd2;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        pc_src     = 1'b1;
                        pc_we      = zero;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_rw    = (opcode == OP_SW);
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_expired) begin
                        set_timeout = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (opcode == OP_LW);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // Reset masks every control line immediately, independent of the clock
        if (rst) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_req    = 1'b0;
            mem_rw     = 1'b0;
            mem_to_reg = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            instr_done = 1'b0;
        end
    end

    // State, wait counter, retire counter and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + 32'd1;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT = 4).
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, ir_we, reg_we, mem_req, mem_rw, mem_to_reg, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic [2:0]  state;
    logic        instr_done;
    logic [31:0] retired;
    logic        illegal;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // strobes = {pc_we, ir_we, reg_we, mem_req, mem_rw, mem_to_reg, pc_src}
    task automatic exp_out(input string tag, input logic [2:0] st, input logic [6:0] strobes,
                           input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                           input logic done);
        logic [16:0] obs;
        logic [16:0] exp;
        obs = {state, pc_we, ir_we, reg_we, mem_req, mem_rw, mem_to_reg, pc_src,
               alu_src_a, alu_src_b, alu_op, instr_done};
        exp = {st, strobes, a, b, op, done};
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        // Reset: FETCH, all strobes masked even though mem_ready is high
        exp_out("reset_outputs", 3'd0, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_flags", {30'd0, illegal, timeout}, 32'd0);
        tick();
        exp_out("reset_held", 3'd0, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0);
        rst = 1'b0;
        #1;

        // add x3,x1,x2: 0,1,2,4,0
        exp_out("add_fetch", 3'd0, 7'b1101000, 2'd0, 2'd1, 2'd0, 1'b0);
        tick(); #1;
        exp_out("add_decode", 3'd1, 7'b0000000, 2'd2, 2'd2, 2'd0, 1'b0);
        tick(); #1;
        exp_out("add_exec", 3'd2, 7'b0000000, 2'd1, 2'd0, 2'b10, 1'b0);
        tick(); #1;
        exp_out("add_wb", 3'd4, 7'b0010000, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("add_retired_before", retired, 32'd0);
        tick(); #1;
        chk("add_retired_after", retired, 32'd1);

        // lw with three wait cycles in MEM
        opcode = OP_LW;
        #1;
        exp_out("lw_fetch", 3'd0, 7'b1101000, 2'd0, 2'd1, 2'd0, 1'b0);
        tick(); tick(); #1;
        exp_out("lw_exec", 3'd2, 7'b0000000, 2'd1, 2'd2, 2'd0, 1'b0);
        tick();
        mem_ready = 1'b0;
        #1;
        exp_out("lw_mem_wait1", 3'd3, 7'b0001000, 2'd1, 2'd2, 2'd0, 1'b0);
        tick(); tick(); tick();
        mem_ready = 1'b1;
        #1;
        exp_out("lw_mem_ready", 3'd3, 7'b0001000, 2'd1, 2'd2, 2'd0, 1'b0);
        chk("lw_no_timeout", {31'd0, timeout}, 32'd0);
        tick(); #1;
        exp_out("lw_wb", 3'd4, 7'b0010010, 2'd0, 2'd0, 2'd0, 1'b1);
        tick(); #1;
        chk("lw_retired", retired, 32'd2);

        // beq taken
        opcode = OP_BEQ;
        zero   = 1'b1;
        tick(); tick(); #1;
        exp_out("beq_taken_exec", 3'd2, 7'b1000001, 2'd1, 2'd0, 2'b01, 1'b1);
        tick(); #1;
        chk("beq_taken_state", 32'(state), 32'd0);
        chk("beq_taken_retired", retired, 32'd3);

        // beq not taken
        zero = 1'b0;
        tick(); tick(); #1;
        exp_out("beq_nt_exec", 3'd2, 7'b0000001, 2'd1, 2'd0, 2'b01, 1'b1);
        tick(); #1;
        chk("beq_nt_retired", retired, 32'd4);

        // sw retires straight out of MEM
        opcode = OP_SW;
        tick(); tick(); tick(); #1;
        exp_out("sw_mem", 3'd3, 7'b0001100, 2'd1, 2'd2, 2'd0, 1'b1);
        tick(); #1;
        exp_out("sw_fetch", 3'd0, 7'b1101000, 2'd0, 2'd1, 2'd0, 1'b0);
        chk("sw_retired", retired, 32'd5);

        // FETCH timeout: four idle cycles then HALT
        mem_ready = 1'b0;
        #1;
        exp_out("to_fetch_wait", 3'd0, 7'b0001000, 2'd0, 2'd1, 2'd0, 1'b0);
        tick(); tick(); tick(); #1;
        chk("to_cycle4_state", {29'd0, state}, 32'd0);
        chk("to_cycle4_flag", {31'd0, timeout}, 32'd0);
        tick(); #1;
        chk("to_halt_state", {29'd0, state}, 32'd7);
        chk("to_halt_flag", {31'd0, timeout}, 32'd1);
        mem_ready = 1'b1;
        tick(); #1;
        exp_out("to_halt_stuck", 3'd7, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("to_halt_sticky", {31'd0, timeout}, 32'd1);
        chk("to_retired_kept", retired, 32'd5);

        // Asynchronous reset clears everything without a clock edge
        rst = 1'b1;
        #1;
        chk("rst_async_state", {29'd0, state}, 32'd0);
        chk("rst_async_flags", {30'd0, illegal, timeout}, 32'd0);
        chk("rst_async_retired", retired, 32'd0);
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        opcode    = OP_R;

        // Ready arriving on the timeout cycle wins
        tick(); tick(); tick();
        mem_ready = 1'b1;
        #1;
        exp_out("race_fetch", 3'd0, 7'b1101000, 2'd0, 2'd1, 2'd0, 1'b0);
        tick(); #1;
        chk("race_state", {29'd0, state}, 32'd1);
        chk("race_no_timeout", {31'd0, timeout}, 32'd0);
        tick(); tick(); tick(); #1;
        chk("race_retired", retired, 32'd1);

        // Illegal opcode
        opcode = OP_BAD;
        tick(); #1;
        exp_out("ill_decode", 3'd1, 7'b0000000, 2'd2, 2'd2, 2'd0, 1'b0);
        tick(); #1;
        chk("ill_state", {29'd0, state}, 32'd7);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_retired", retired, 32'd1);
        rst = 1'b1;
        #1;
        chk("ill_rst_flag", {31'd0, illegal}, 32'd0);
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;

        // Retire counter wrap from all-ones
        #1;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("wrap_preload", retired, 32'hFFFF_FFFF);
        opcode    = OP_BEQ;
        zero      = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick(); #1;
        chk("wrap_state", {29'd0, state}, 32'd0);
        chk("wrap_retired", retired, 32'd0);

        // Reset during a stalled sw MEM access
        opcode = OP_SW;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        exp_out("sw_rst_mem", 3'd3, 7'b0001100, 2'd1, 2'd2, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("sw_rst_memreq", {30'd0, mem_req, mem_rw}, 32'd0);
        chk("sw_rst_state", {29'd0, state}, 32'd0);
        chk("sw_rst_retired", retired, 32'd0);
        tick();
        rst = 1'b0;
        tick(); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: CLK in 1, clock; all state changes on rising edge.
REQ-002 SHALL have ports: RST in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: OPCODE in 7, instruction-register bits [6:0], stable after FETCH.
REQ-004 SHALL have ports: ZERO in 1, ALU zero flag; MEM_READY in 1, memory access-complete handshake.
REQ-005 SHALL have ports: PC_WE, IR_WE, REG_WE, MEM_REQ, MEM_RW (0 read, 1 write), MEM_TO_REG, PC_SRC (0 ALU result, 1 branch target) out 1 each.
REQ-006 SHALL have ports: ALU_SRC_A out 2 (0 PC, 1 RD1, 2 old PC), ALU_SRC_B out 2 (0 RD2, 1 const 4, 2 sign_out), ALU_OP out 2 (00 add, 01 sub, 10 funct-decoded).
REQ-007 SHALL have ports: STATE out 3; INSTR_DONE out 1 (retire pulse); RETIRED out 32 (retired count); ILLEGAL out 1; TIMEOUT out 1.
REQ-008 Parameter: MEM_TIMEOUT, default 255, max MEM_READY wait cycles before halt.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; codes 5,6 SHALL go to HALT.
REQ-010 Outputs SHALL be combinational from state plus OPCODE/ZERO/MEM_READY; unlisted strobes 0, mux selects 0.
REQ-011 FETCH: MEM_REQ=1, MEM_RW=0, A=0, B=1, ALU_OP=00; stay until MEM_READY=1; that cycle IR_WE=1, PC_WE=1, PC_SRC=0; next DECODE.
REQ-012 DECODE: A=2, B=2, ALU_OP=00 (branch target); OPCODE in {0110011, 0010011, 0000011, 0100011, 1100011} -> EXEC, else set ILLEGAL -> HALT.
REQ-013 EXEC R-type (0110011): A=1, B=0, ALU_OP=10 -> WB.
REQ-014 EXEC I-ALU (0010011): A=1, B=2, ALU_OP=10 -> WB.
REQ-015 EXEC LW/SW: A=1, B=2, ALU_OP=00 -> MEM.
REQ-016 EXEC BEQ: A=1, B=0, ALU_OP=01, PC_SRC=1, PC_WE=ZERO; retire -> FETCH.
REQ-017 MEM: MEM_REQ=1, MEM_RW=1 for SW else 0, address held (A=1, B=2, ALU_OP=00); wait MEM_READY; SW retire -> FETCH, LW -> WB.
REQ-018 WB: REG_WE=1, MEM_TO_REG=1 for LW else 0; retire -> FETCH.
REQ-019 Retire: INSTR_DONE=1 for exactly the one cycle; RETIRED increments that edge, wraps 0xFFFFFFFF -> 0.
REQ-020 Wait counter: clears on entering FETCH/MEM; increments each cycle MEM_REQ=1 and MEM_READY=0; reaching MEM_TIMEOUT sets TIMEOUT and -> HALT, no strobes that cycle.
REQ-021 MEM_READY=1 on the cycle the count reaches MEM_TIMEOUT SHALL win (access completes, no TIMEOUT).
REQ-022 MEM_READY outside FETCH/MEM SHALL be ignored.
REQ-023 HALT: all strobes 0, MEM_REQ=0; ILLEGAL/TIMEOUT sticky; exit only by RST.

Reset
REQ-024 RST=1 SHALL immediately, without CLK, force STATE=FETCH, RETIRED=0, wait count 0, ILLEGAL=0, TIMEOUT=0, INSTR_DONE=0.
REQ-025 While RST=1 all strobes (PC_WE, IR_WE, REG_WE, MEM_REQ, MEM_RW) SHALL be 0; FETCH begins first rising edge after release.
REQ-026 RST asserted mid-MEM (SW) SHALL drop MEM_REQ/MEM_RW same cycle; no partial retire counted.

Verification
REQ-027 add x3,x1,x2 (0110011), MEM_READY=1 in FETCH -> states 0,1,2,4,0; REG_WE=1 in WB only; RETIRED 0->1 after 4 cycles.
REQ-028 lw (0000011), MEM_READY low 3 cycles in MEM -> MEM held 4 cycles, then WB with MEM_TO_REG=1; 5+3 cycles total.
REQ-029 beq ZERO=1 -> PC_WE=1, PC_SRC=1 in EXEC; ZERO=0 -> PC_WE=0; both retire, 3 cycles.
REQ-030 OPCODE=1111111 -> HALT after DECODE, ILLEGAL=1, RETIRED unchanged; RST then FETCH.
REQ-031 MEM_TIMEOUT=4, MEM_READY held 0 in FETCH -> TIMEOUT=1, STATE=7 after 4 cycles; variant MEM_READY=1 at cycle 4 -> DECODE, TIMEOUT=0.
REQ-032 Preload RETIRED to 0xFFFFFFFF via 2^32-1 retires (or force) -> next retire gives 0; RST mid-sw MEM -> MEM_REQ=0 immediately, RETIRED=0.
